// File: rtl/sub16_seq.sv
// Digit-serial subtractor: diff = a - b, one DIGIT-wide slice per cycle, LSB first, borrow registered between slices.
// Latency WIDTH/DIGIT cycles after an accepted start; start is ignored while busy, and results are held until the next start.
module sub16_seq #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             zero,
   output logic             ovf
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
   logic             bin_q, bin_d, borrow_q, borrow_d;
   logic             zero_q, zero_d, ovf_q, ovf_d;
   logic [DIGIT:0]   sub_w;
   int               lsb;

   assign lsb = int'(cnt_q) * DIGIT;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      bin_d    = bin_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      sub_w    = '0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d      = a;
               b_d      = b;
               bin_d    = 1'b0;
               cnt_d    = '0;
               diff_d   = '0;
               borrow_d = 1'b0;
               zero_d   = 1'b0;
               ovf_d    = 1'b0;
               state_d  = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            // Only a DIGIT-wide subtract sits between the registers each cycle.
            sub_w = {1'b0, a_q[lsb +: DIGIT]} - {1'b0, b_q[lsb +: DIGIT]} - {{DIGIT{1'b0}}, bin_q};
            diff_d[lsb +: DIGIT] = sub_w[DIGIT-1:0];
            bin_d = sub_w[DIGIT];
            if (cnt_q == CW'(NDIG - 1)) begin
               state_d  = DONE;
               borrow_d = sub_w[DIGIT];
               zero_d   = (diff_d == '0);
               ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff_d[WIDTH-1] != a_q[WIDTH-1]);
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         bin_q    <= 1'b0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         bin_q    <= bin_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
      end
   end

   assign busy   = (state_q == RUN);
   assign done   = (state_q == DONE);
   assign diff   = diff_q;
   assign borrow = borrow_q;
   assign zero   = zero_q;
   assign ovf    = ovf_q;

endmodule

// File: tb/tb_sub16_seq.sv
// Bench for sub16_seq: vector table plus random operands through a scoreboard, and hand sequences for hold, back-to-back, ignored start and reset abort.
module tb_sub16_seq;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [15:0] a, b;
   logic        busy, done, borrow, zero, ovf;
   logic [15:0] diff;

   sub16_seq #(.WIDTH(16), .DIGIT(4)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .diff(diff),
      .borrow(borrow), .zero(zero), .ovf(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a, b, diff;
      logic        borrow, zero, ovf;
   } vec_t;

   vec_t sb[$];
   vec_t tbl[9];
   int   chk_cnt = 0;
   int   pass_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic vec_t model(input logic [15:0] x, input logic [15:0] y);
      vec_t v;
      v.a      = x;
      v.b      = y;
      v.diff   = x - y;
      v.borrow = (x < y);
      v.zero   = (v.diff == 16'h0);
      v.ovf    = (x[15] != y[15]) && (v.diff[15] != x[15]);
      return v;
   endfunction

   function automatic vec_t mk(input logic [15:0] x, input logic [15:0] y, input logic [15:0] d,
                               input logic br, input logic z, input logic o);
      vec_t v;
      v.a = x; v.b = y; v.diff = d; v.borrow = br; v.zero = z; v.ovf = o;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input vec_t v);
      start = 1'b1; a = v.a; b = v.b;
      sb.push_back(v);
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(output int n, output int bcnt);
      n = 0; bcnt = 0;
      while (!done && n < 30) begin
         if (busy) bcnt++;
         tick();
         n++;
      end
      check("done_seen", done, 1);
   endtask

   task automatic compare_out(input string tag);
      vec_t v;
      if (sb.size() == 0) begin
         check({tag, "_sb_nonempty"}, 0, 1);
      end else begin
         v = sb.pop_front();
         check({tag, "_diff"}, diff, v.diff);
         check({tag, "_borrow"}, borrow, v.borrow);
         check({tag, "_zero"}, zero, v.zero);
         check({tag, "_ovf"}, ovf, v.ovf);
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int n, bc;
      issue(v);
      check({tag, "_busy_after_start"}, busy, 1);
      check({tag, "_diff_cleared"}, diff, 0);
      wait_done(n, bc);
      check({tag, "_latency"}, n, 4);
      check({tag, "_busy_cycles"}, bc, 4);
      compare_out(tag);
      tick();
      check({tag, "_done_one_cycle"}, done, 0);
      check({tag, "_idle_busy"}, busy, 0);
   endtask

   initial begin
      int   n, bc, dcnt;
      vec_t v;

      tbl[0] = mk(16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 1'b0);
      tbl[1] = mk(16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      tbl[2] = mk(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1);
      tbl[3] = mk(16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 1'b1);
      tbl[4] = mk(16'h5555, 16'h5555, 16'h0000, 1'b0, 1'b1, 1'b0);
      tbl[5] = mk(16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0);
      tbl[6] = mk(16'h0000, 16'h8000, 16'h8000, 1'b1, 1'b0, 1'b1);
      tbl[7] = mk(16'h7FFF, 16'h8000, 16'hFFFF, 1'b1, 1'b0, 1'b1);
      tbl[8] = mk(16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b0, 1'b0);

      // Reset state
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      tick(); tick();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_diff", diff, 0);
      check("rst_borrow", borrow, 0);
      check("rst_zero", zero, 0);
      check("rst_ovf", ovf, 0);
      rst = 1'b0;
      tick();

      foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 6; i++) begin
         v = model(16'($urandom), 16'($urandom));
         run_vec(v, $sformatf("rnd%0d", i));
      end

      // Result held across idle cycles
      run_vec(tbl[4], "hold");
      dcnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (done) dcnt++;
         tick();
      end
      check("hold_no_done", dcnt, 0);
      check("hold_diff", diff, 16'h0000);
      check("hold_zero", zero, 1);
      check("hold_busy", busy, 0);

      // Start mid-RUN ignored, then back-to-back start in the done cycle
      issue(mk(16'h0100, 16'h0001, 16'h00FF, 1'b0, 1'b0, 1'b0));
      tick();
      start = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
      tick();
      start = 1'b0;
      check("ign_busy", busy, 1);
      wait_done(n, bc);
      check("ign_remaining", n, 2);
      compare_out("ign");
      issue(model(16'h0003, 16'h0005));
      check("b2b_done_drop", done, 0);
      check("b2b_busy", busy, 1);
      check("b2b_diff_clr", diff, 0);
      check("b2b_borrow_clr", borrow, 0);
      wait_done(n, bc);
      check("b2b_done_spacing", n + 1, 5);
      compare_out("b2b");
      tick();

      // Reset mid-RUN aborts without done
      start = 1'b1; a = 16'h1234; b = 16'h0234;
      tick();
      start = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_diff", diff, 0);
      check("abort_borrow", borrow, 0);
      check("abort_zero", zero, 0);
      check("abort_ovf", ovf, 0);
      dcnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (done) dcnt++;
         tick();
      end
      check("abort_no_done", dcnt, 0);
      run_vec(model(16'hA5A5, 16'h5A5A), "after_abort");

      check("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
